// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the EX/MEM/WB stage state and pipeline
// register records.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // Memory-side stage state: running, waiting on data memory, halted.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HALTED = 2'd2
    } stage_state_t;

    // EX/MEM pipeline register contents.
    typedef struct packed {
        logic     valid;
        logic     regwr;
        logic     memrd;
        logic     memwr;
        logic     halt;
        regbits_t rd;
        regbits_t rt;
        word_t    aluout;
        word_t    store;
    } mem_reg_t;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic     valid;
        logic     regwr;
        logic     halt;
        regbits_t rd;
        word_t    data;
    } wb_reg_t;

    // True when the instruction held in M needs the data memory.
    function automatic logic is_mem_op(input mem_reg_t m);
        return m.valid && (m.memrd || m.memwr);
    endfunction

endpackage

// File: rtl/ex_mem_wb_stage.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory handshake.
// A memory op in M is requested every cycle until dhit; while waiting the
// upstream is stalled and W receives bubbles. A retired halt freezes the
// stage until reset.
module ex_mem_wb_stage
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ex_valid,
    input  logic     ex_regwr,
    input  logic     ex_memrd,
    input  logic     ex_memwr,
    input  logic     ex_halt,
    input  regbits_t ex_rd,
    input  regbits_t ex_rt,
    input  word_t    ex_aluout,
    input  word_t    ex_store,
    input  logic     flush,
    input  logic     dhit,
    input  word_t    dload,
    output logic     dREN,
    output logic     dWEN,
    output word_t    daddr,
    output word_t    dstore,
    output logic     stall_up,
    output regbits_t rd_mem,
    output regbits_t mem_rt,
    output logic     wr_mem,
    output logic     wm_mem,
    output word_t    mem_fwd_data,
    output regbits_t rd_wb,
    output logic     wr_wb,
    output word_t    wb_data,
    output logic     halt
);

    stage_state_t state_q;
    mem_reg_t     m_q, m_d;
    wb_reg_t      w_q, w_d;
    logic         advance;

    // Data-memory request and stall, derived from M, state and dhit only.
    always_comb begin
        dREN     = m_q.valid && m_q.memrd && (state_q != ST_HALTED);
        dWEN     = m_q.valid && m_q.memwr && (state_q != ST_HALTED);
        daddr    = m_q.aluout;
        dstore   = m_q.store;
        stall_up = (dREN || dWEN) && !dhit;
        advance  = !stall_up && (state_q != ST_HALTED);
    end

    // Forwarding, write-back and status outputs.
    always_comb begin
        rd_mem       = m_q.rd;
        mem_rt       = m_q.rt;
        wr_mem       = m_q.valid && m_q.regwr;
        wm_mem       = m_q.valid && m_q.memwr;
        mem_fwd_data = m_q.aluout;
        rd_wb        = w_q.rd;
        wr_wb        = w_q.valid && w_q.regwr && (w_q.rd != '0);
        wb_data      = w_q.data;
        halt         = (state_q == ST_HALTED);
    end

    // Next EX/MEM contents: capture EX on advance (flush squashes), else hold.
    always_comb begin
        m_d = m_q;
        if (advance) begin
            m_d.valid  = ex_valid && !flush;
            m_d.regwr  = ex_regwr;
            m_d.memrd  = ex_memrd;
            m_d.memwr  = ex_memwr;
            m_d.halt   = ex_halt;
            m_d.rd     = ex_rd;
            m_d.rt     = ex_rt;
            m_d.aluout = ex_aluout;
            m_d.store  = ex_store;
        end
    end

    // Next MEM/WB contents: retire M on advance, otherwise insert a bubble.
    always_comb begin
        w_d = w_q;
        if (advance) begin
            w_d.valid = m_q.valid;
            w_d.regwr = m_q.regwr;
            w_d.halt  = m_q.halt;
            w_d.rd    = m_q.rd;
            w_d.data  = m_q.memrd ? dload : m_q.aluout;
        end else begin
            w_d.valid = 1'b0;
        end
    end

    // Pipeline registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_q <= '0;
            w_q <= '0;
        end else begin
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    // Stage FSM: retired halt wins over the memory wait handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
        end else if (w_q.valid && w_q.halt) begin
            state_q <= ST_HALTED;
        end else begin
            case (state_q)
                ST_RUN:    if (is_mem_op(m_q) && !dhit) state_q <= ST_WAIT;
                ST_WAIT:   if (dhit) state_q <= ST_RUN;
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_RUN;
            endcase
        end
    end

endmodule
